master_tx_serializer: RTL and testbench
=======================================

// Module: master_tx_serializer
// PURPOSE
//  Master-side transmit stage directly upstream of the slave input port on the serial system bus.
//  Accepts one parallel request (addr, burst length, R/W) plus per-beat write data from a master FIFO.
//  Shifts them out bit-serially on tx_address/tx_burst/tx_data, one bit per master_valid & slave_ready handshake.
//  Drives write_enable/read_enable for the whole transaction; pulses done at the end.
// PARAMETERS
//  ADDR_LEN   12  address bits shifted on tx_address
//  DATA_LEN   8   bits per data beat on tx_data
//  BURST_LEN  12  burst-field bits on tx_burst; must be <= ADDR_LEN
// PORTS
//  clk           in   1          clock, all logic on rising edge
//  reset         in   1          reset, synchronous, active-high
//  req_valid     in   1          request present
//  req_ready     out  1          request accepted when req_valid & req_ready
//  req_write     in   1          1 = write, 0 = read
//  req_addr      in   ADDR_LEN   target address
//  req_burst     in   BURST_LEN  beats minus one (0 = single beat)
//  data_valid    in   1          write word available
//  data_ready    out  1          1-cycle pop strobe; data_in is captured on that edge
//  data_in       in   DATA_LEN   write data word
//  slave_busy    in   1          slave cannot start a transaction
//  slave_ready   in   1          slave accepts the current bit
//  master_valid  out  1          current bit(s) valid on the tx lines
//  tx_address    out  1          serial address, LSB first
//  tx_burst      out  1          serial burst field, LSB first
//  tx_data       out  1          serial data, LSB first
//  write_enable  out  1          high from HEADER through the last data bit of a write
//  read_enable   out  1          high during HEADER of a read
//  busy          out  1          state != IDLE
//  done          out  1          1-cycle pulse at transaction end
// BEHAVIOUR
//  Reset: state=IDLE. Counters and shift registers are cleared. All outputs are 0. Reset overrides any state mid-transfer; the partial transfer is abandoned and no done pulse is issued.
//  req_ready = (state==IDLE) & ~reset & ~slave_busy. On acceptance, addr, burst and write are latched and the FSM goes to HEADER.
//  HEADER: master_valid=1.
//   - tx_address = addr[bit_cnt]. tx_burst = burst[bit_cnt] while bit_cnt<BURST_LEN, otherwise 0.
//   - bit_cnt advances only on a handshake; when slave_ready=0, lines and bit_cnt hold.
//   - After the handshake on bit ADDR_LEN-1: a write goes to LOAD, a read goes to DONE.
//  LOAD: master_valid=0.
//   - If data_valid: data_ready=1 for that cycle, shreg<=data_in, bit_cnt<=0, go to SHIFT.
//   - Otherwise wait in LOAD, with no timeout.
//  SHIFT: master_valid=1, tx_data=shreg[0].
//   - On each handshake, shreg shifts right and bit_cnt increments.
//   - After the last bit of a beat: if beat_cnt==burst, go to DONE; else beat_cnt++ and go to LOAD.
//  DONE: done=1 for exactly one cycle, then IDLE. req_ready is 0 in DONE.
//  beat_cnt is BURST_LEN bits wide. req_burst=0 gives 1 beat; all-ones gives 2^BURST_LEN beats, with no wrap before the compare.
//  Latency, write, slave_ready tied high, accept at edge 0:
//   - HEADER cycles 1..ADDR_LEN; LOAD 1 cycle per beat; SHIFT DATA_LEN cycles per beat; then done.
//  slave_busy is sampled only in IDLE; changes mid-transaction are ignored.
//  req_* inputs are ignored outside IDLE. data_valid is ignored outside LOAD.
// CONFIGURATION
//  MASTER_TX_PARITY_EN defined:
//   - Each beat sends DATA_LEN data bits, then 1 even-parity bit (XOR of the word) on tx_data. SHIFT lasts DATA_LEN+1 handshakes.
//   - Header parity is not sent.
//  Not defined: SHIFT lasts DATA_LEN handshakes and no parity logic exists.
// TESTING
//  1. Write addr=0xA5C, burst=0, data 0x3C, slave_ready=1:
//     - HEADER cycles 1-12: tx_address LSB-first 0,0,1,1,1,0,1,0,0,1,0,1.
//     - data_ready in cycle 13; tx_data 0,0,1,1,1,1,0,0 in cycles 14-21; done in cycle 22.
//  2. Write burst=2, data 0x01,0x02,0x80:
//     - exactly 3 data_ready pulses and 24 tx_data handshakes; done once; write_enable low after DONE.
//  3. Read addr=0x123, burst=5:
//     - tx_burst carries 1,0,1,0...0; read_enable high for the 12 HEADER cycles.
//     - no data_ready; done on the cycle after the last header handshake.
//  4. slave_ready low for 3 cycles mid-SHIFT, and data_valid low for 4 cycles in LOAD:
//     - tx lines and counters frozen; master_valid=0 in LOAD; final serial stream unchanged.
//  5. slave_busy=1 with req_valid=1:
//     - req_ready=0 and no transfer; acceptance happens the cycle after slave_busy falls.
//     - reset asserted mid-SHIFT: next cycle IDLE, all outputs 0, no done pulse.
//  6. MASTER_TX_PARITY_EN, data 0x07: 9 tx_data bits 1,1,1,0,0,0,0,0,1; without the macro, 8 bits.

Source files
------------

// File: rtl/master_tx_serializer.sv
// Master-side bit-serial transmit stage: a parallel request (addr, burst, R/W) plus write beats go out
// one bit per master_valid & slave_ready handshake. Optional macro MASTER_TX_PARITY_EN appends an even-parity bit to each beat.
module master_tx_serializer #(
  parameter int ADDR_LEN  = 12,
  parameter int DATA_LEN  = 8,
  parameter int BURST_LEN = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_LEN-1:0]  req_addr,
  input  logic [BURST_LEN-1:0] req_burst,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic [DATA_LEN-1:0]  data_in,
  input  logic                 slave_busy,
  input  logic                 slave_ready,
  output logic                 master_valid,
  output logic                 tx_address,
  output logic                 tx_burst,
  output logic                 tx_data,
  output logic                 write_enable,
  output logic                 read_enable,
  output logic                 busy,
  output logic                 done
);

`ifdef MASTER_TX_PARITY_EN
  localparam int SH_W = DATA_LEN + 1;
`else
  localparam int SH_W = DATA_LEN;
`endif
  localparam int MAXB  = (ADDR_LEN > SH_W) ? ADDR_LEN : SH_W;
  localparam int CNT_W = (MAXB > 1) ? $clog2(MAXB) : 1;

  localparam logic [CNT_W-1:0]     ADDR_LAST = CNT_W'(ADDR_LEN - 1);
  localparam logic [CNT_W-1:0]     SH_LAST   = CNT_W'(SH_W - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
  localparam logic [BURST_LEN-1:0] BEAT_ONE  = BURST_LEN'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t               state, state_nx;
  logic [ADDR_LEN-1:0]  addr_sh;
  logic [BURST_LEN-1:0] burst_sh;
  logic [BURST_LEN-1:0] burst_q;
  logic [BURST_LEN-1:0] beat_cnt;
  logic                 wr_q;
  logic [SH_W-1:0]      shreg;
  logic [SH_W-1:0]      load_word;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 accept;

`ifdef MASTER_TX_PARITY_EN
  // Parity rides as the top bit of the shift register so it simply falls out after the data bits.
  assign load_word = {^data_in, data_in};
`else
  assign load_word = data_in;
`endif

  assign accept = (state == ST_IDLE) & req_valid & ~slave_busy;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    req_ready    = 1'b0;
    data_ready   = 1'b0;
    master_valid = 1'b0;
    tx_address   = 1'b0;
    tx_burst     = 1'b0;
    tx_data      = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = ~slave_busy;
        if (accept) state_nx = ST_HEADER;
      end
      ST_HEADER: begin
        master_valid = 1'b1;
        tx_address   = addr_sh[0];
        tx_burst     = burst_sh[0];
        write_enable = wr_q;
        read_enable  = ~wr_q;
        busy         = 1'b1;
        if (slave_ready && bit_cnt == ADDR_LAST) state_nx = wr_q ? ST_LOAD : ST_DONE;
      end
      ST_LOAD: begin
        write_enable = wr_q;
        busy         = 1'b1;
        data_ready   = data_valid;
        if (data_valid) state_nx = ST_SHIFT;
      end
      ST_SHIFT: begin
        master_valid = 1'b1;
        tx_data      = shreg[0];
        write_enable = wr_q;
        busy         = 1'b1;
        if (slave_ready && bit_cnt == SH_LAST)
          state_nx = (beat_cnt == burst_q) ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    // Reset holds every output low in the same cycle, not just after the edge.
    if (reset) begin
      req_ready    = 1'b0;
      data_ready   = 1'b0;
      master_valid = 1'b0;
      tx_address   = 1'b0;
      tx_burst     = 1'b0;
      tx_data      = 1'b0;
      write_enable = 1'b0;
      read_enable  = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_sh  <= '0;
      burst_sh <= '0;
      burst_q  <= '0;
      beat_cnt <= '0;
      wr_q     <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            addr_sh  <= req_addr;
            burst_sh <= req_burst;
            burst_q  <= req_burst;
            wr_q     <= req_write;
            bit_cnt  <= '0;
            beat_cnt <= '0;
          end
        end
        ST_HEADER: begin
          // Zero fill makes tx_burst read 0 once the burst field is exhausted.
          if (slave_ready) begin
            addr_sh  <= addr_sh >> 1;
            burst_sh <= burst_sh >> 1;
            bit_cnt  <= (bit_cnt == ADDR_LAST) ? '0 : bit_cnt + CNT_ONE;
          end
        end
        ST_LOAD: begin
          if (data_valid) begin
            shreg   <= load_word;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (slave_ready) begin
            shreg <= shreg >> 1;
            if (bit_cnt == SH_LAST) begin
              bit_cnt <= '0;
              // Compare before increment so all-ones burst never wraps.
              if (beat_cnt != burst_q) beat_cnt <= beat_cnt + BEAT_ONE;
            end else begin
              bit_cnt <= bit_cnt + CNT_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_master_tx_serializer.sv
// Bench for master_tx_serializer: directed and randomized transactions; observed serial streams are
// reassembled into words and compared against the requested address/burst/data.
module tb_master_tx_serializer;
  localparam int AL = 12;
  localparam int DL = 8;
  localparam int BL = 12;
`ifdef MASTER_TX_PARITY_EN
  localparam int SW = DL + 1;
`else
  localparam int SW = DL;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [AL-1:0] req_addr;
  logic [BL-1:0] req_burst;
  logic          data_valid, data_ready;
  logic [DL-1:0] data_in;
  logic          slave_busy, slave_ready;
  logic          master_valid, tx_address, tx_burst, tx_data;
  logic          write_enable, read_enable, busy, done;

  master_tx_serializer #(.ADDR_LEN(AL), .DATA_LEN(DL), .BURST_LEN(BL)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_burst(req_burst),
    .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
    .slave_busy(slave_busy), .slave_ready(slave_ready),
    .master_valid(master_valid), .tx_address(tx_address), .tx_burst(tx_burst), .tx_data(tx_data),
    .write_enable(write_enable), .read_enable(read_enable), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // per-transaction observation record
  int            cyc = 0;
  int            acc_cyc, first_dr_cyc, done_cyc;
  int            n_dr, n_done, n_hhs, n_dhs, n_re, en_err, stall_err, beat_bit, pop_idx;
  logic [63:0]   got_addr, got_burst;
  logic [SW-1:0] beat_word;
  logic [SW-1:0] got_beats[$];
  logic [DL-1:0] wq[$];
  logic          cur_wr, prev_stall, s_req_ready;
  logic [2:0]    prev_lines;
  int            sr_pct = 100, dv_pct = 100;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [SW-1:0] exp_beat(input logic [DL-1:0] w);
`ifdef MASTER_TX_PARITY_EN
    return {^w, w};
`else
    return w;
`endif
  endfunction

  function automatic logic [9:0] all_outs();
    return {req_ready, data_ready, master_valid, tx_address, tx_burst, tx_data,
            write_enable, read_enable, busy, done};
  endfunction

  task automatic clear_rec();
    n_dr = 0; n_done = 0; n_hhs = 0; n_dhs = 0; n_re = 0; en_err = 0; stall_err = 0;
    beat_bit = 0; pop_idx = 0; got_addr = '0; got_burst = '0; beat_word = '0;
    got_beats.delete(); prev_stall = 1'b0; prev_lines = '0;
    acc_cyc = -1; first_dr_cyc = -1; done_cyc = -1;
  endtask

  task automatic sample();
    s_req_ready = req_ready;
    if (prev_stall && (!master_valid || {tx_address, tx_burst, tx_data} !== prev_lines)) stall_err++;
    prev_stall = master_valid & ~slave_ready;
    prev_lines = {tx_address, tx_burst, tx_data};
    if (read_enable) n_re++;
    if (done) begin
      n_done++; done_cyc = cyc;
      if (write_enable || read_enable || master_valid) en_err++;
    end
    if (data_ready) begin
      if (n_dr == 0) first_dr_cyc = cyc;
      n_dr++; pop_idx++;
      if (master_valid || !write_enable) en_err++;
    end
    if (master_valid && (cur_wr ? (!write_enable || read_enable) : (!read_enable || write_enable))) en_err++;
    if (master_valid && slave_ready) begin
      if (n_dr == 0) begin
        if (n_hhs < 64) begin got_addr[n_hhs] = tx_address; got_burst[n_hhs] = tx_burst; end
        n_hhs++;
      end else begin
        beat_word[beat_bit] = tx_data;
        beat_bit++; n_dhs++;
        if (beat_bit == SW) begin got_beats.push_back(beat_word); beat_bit = 0; end
      end
    end
  endtask

  // Inputs are driven just after a rising edge, outputs sampled mid-cycle, then the next edge.
  task automatic step();
    slave_ready = ($urandom_range(99) < sr_pct);
    data_valid  = ($urandom_range(99) < dv_pct);
    data_in     = (pop_idx < wq.size()) ? wq[pop_idx] : DL'($urandom);
    #2;
    sample();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic start_txn(input logic wr, input logic [AL-1:0] a, input logic [BL-1:0] b);
    int guard;
    clear_rec();
    cur_wr = wr;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_burst = b;
    guard = 0;
    s_req_ready = 1'b0;
    while (!s_req_ready && guard < 200) begin step(); guard++; end
    acc_cyc = cyc - 1;
    chk("accept_bound", 64'(s_req_ready), 64'(1));
    // garbage on req_* must be ignored while busy
    req_valid = 1'b0; req_write = ~wr; req_addr = AL'($urandom); req_burst = BL'($urandom);
  endtask

  task automatic run_txn(input logic wr, input logic [AL-1:0] a, input logic [BL-1:0] b);
    int guard;
    int nb;
    start_txn(wr, a, b);
    guard = 0;
    while (n_done == 0 && guard < 5000) begin step(); guard++; end
    chk("done_bound", 64'(n_done > 0), 64'(1));
    step(); step();
    nb = wr ? int'(b) + 1 : 0;
    chk("hdr_hs", 64'(n_hhs), 64'(AL));
    chk("addr", got_addr[AL-1:0], 64'(a));
    chk("burst", got_burst[BL-1:0], 64'(b));
    chk("done_cnt", 64'(n_done), 64'(1));
    chk("dr_cnt", 64'(n_dr), 64'(nb));
    chk("data_hs", 64'(n_dhs), 64'(nb * SW));
    for (int i = 0; i < nb && i < got_beats.size(); i++)
      chk("beat", 64'(got_beats[i]), 64'(exp_beat(wq[i])));
    chk("enables", 64'(en_err), 64'(0));
    chk("stall_hold", 64'(stall_err), 64'(0));
    chk("idle_after", {62'd0, busy, write_enable}, 64'(0));
  endtask

  initial begin
    logic [AL-1:0] ra;
    logic [BL-1:0] rb;
    logic          rw;
    int            err, guard;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_burst = '0;
    data_valid = 1'b0; data_in = '0; slave_busy = 1'b0; slave_ready = 1'b0;
    clear_rec();
    cur_wr = 1'b0;
    @(posedge clk); #1;
    step();
    chk("reset_outs", 64'(all_outs()), 64'(0));
    reset = 1'b0;
    step();
    chk("idle_ready", {62'd0, busy, req_ready}, 64'(1));

    // 1: write A5C, single beat 3C, no stalls; latency check
    sr_pct = 100; dv_pct = 100;
    wq = '{8'h3C};
    run_txn(1'b1, 12'hA5C, 12'd0);
    chk("lat_dr", 64'(first_dr_cyc - acc_cyc), 64'(AL + 1));
    chk("lat_done", 64'(done_cyc - acc_cyc), 64'(AL + SW + 2));

    // 2: burst of three
    wq = '{8'h01, 8'h02, 8'h80};
    run_txn(1'b1, 12'h3F0, 12'd2);

    // 3: read 123, burst 5
    run_txn(1'b0, 12'h123, 12'd5);
    chk("read_en_cycles", 64'(n_re), 64'(AL));
    chk("read_lat", 64'(done_cyc - acc_cyc), 64'(AL + 1));

    // 4: slave_ready and data_valid stalls
    sr_pct = 55; dv_pct = 40;
    wq = '{8'hA5, 8'h5A};
    run_txn(1'b1, 12'h0F1, 12'd1);

    // 5: slave_busy holds off acceptance
    sr_pct = 100; dv_pct = 100;
    slave_busy = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h777; req_burst = '0;
    err = 0;
    for (int i = 0; i < 4; i++) begin step(); if (s_req_ready || busy) err++; end
    chk("busy_block", 64'(err), 64'(0));
    slave_busy = 1'b0;
    step();
    chk("busy_release_ready", 64'(s_req_ready), 64'(1));
    req_valid = 1'b0;
    slave_busy = 1'b1;
    step();
    chk("accepted_after_release", 64'(busy), 64'(1));
    guard = 0;
    while (busy && guard < 100) begin step(); guard++; end
    slave_busy = 1'b0;
    chk("busy_txn_end", 64'(busy), 64'(0));

    // reset mid-SHIFT abandons transfer without done
    wq = '{8'hC3, 8'h99};
    start_txn(1'b1, 12'h456, 12'd1);
    guard = 0;
    while (n_dhs < 3 && guard < 100) begin step(); guard++; end
    chk("reach_shift", 64'(n_dhs >= 3), 64'(1));
    reset = 1'b1;
    step();
    chk("reset_mid_outs", 64'(all_outs() & 10'h1FF), 64'(0));
    reset = 1'b0;
    err = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done || busy || master_valid || write_enable || data_ready) err++;
    end
    chk("post_reset_quiet", 64'(err), 64'(0));
    chk("no_done_after_reset", 64'(n_done), 64'(0));

    // 6: data 0x07 beat (parity bit included when enabled)
    wq = '{8'h07};
    run_txn(1'b1, 12'h001, 12'd0);

    // randomized transactions
    for (int t = 0; t < 10; t++) begin
      rw = 1'($urandom_range(1));
      ra = AL'($urandom);
      rb = BL'($urandom_range(4));
      sr_pct = $urandom_range(50, 100);
      dv_pct = $urandom_range(30, 100);
      wq.delete();
      for (int k = 0; k <= int'(rb); k++) wq.push_back(DL'($urandom));
      run_txn(rw, ra, rb);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
